// File: rtl/incubator_pkg.sv
// Shared types and constants for the multi-zone incubator controller.
package incubator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COOL = 2'd1,
        HEAT = 2'd2
    } mode_t;

    // Register width able to hold values 0 .. n-1 (at least one bit).
    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_THR_HI     = 35;
    localparam int DEF_THR_HI_CLR = 25;
    localparam int DEF_THR_LO     = 15;
    localparam int DEF_THR_LO_CLR = 30;
    localparam int DEF_THR_ALARM  = 50;

endpackage

// File: rtl/incubator_zone.sv
// One incubator zone: thermostat FSM, fan level FSM, min-on timer and alarm.
// Sensor watchdog is built only when INCUBATOR_SENSOR_WDT_EN is defined.
module incubator_zone
    import incubator_pkg::*;
#(
    parameter int TW        = 8,
    parameter int FAN_LVLS  = 4,
    parameter int FAN_T0    = 35,
    parameter int FAN_STEP  = 5,
    parameter int FAN_HYS   = 5,
    parameter int RPS_W     = 4,
    parameter int RPS_BASE  = 4,
    parameter int RPS_STEP  = 2,
    parameter int MIN_ON    = 16,
    parameter int ALARM_CNT = 4
`ifdef INCUBATOR_SENSOR_WDT_EN
    ,
    parameter int WDT_CYC   = 1024
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_valid,
    input  logic [TW-1:0]    t,
    input  logic [TW-1:0]    thr_hi,
    input  logic [TW-1:0]    thr_hi_clr,
    input  logic [TW-1:0]    thr_lo,
    input  logic [TW-1:0]    thr_lo_clr,
    input  logic [TW-1:0]    thr_alarm,
    input  logic             alarm_clr,
    output logic             cooler,
    output logic             heater,
    output logic [RPS_W-1:0] rps,
    output logic             alarm,
    output logic             fault,
    output logic [1:0]       mode_dbg
);

    localparam int LW  = cw(FAN_LVLS);
    localparam int TMW = cw(MIN_ON);
    localparam int AW  = cw(ALARM_CNT + 1);
    localparam int XW  = TW + 4;
    localparam logic [LW-1:0]  LVL_MAX = LW'(FAN_LVLS - 1);
    localparam logic [TMW-1:0] T_LOAD  = TMW'(MIN_ON - 1);
    localparam logic [AW-1:0]  A_MAX   = AW'(ALARM_CNT);

    mode_t            mode, mode_n;
    logic [LW-1:0]    lvl, lvl_n;
    logic [TMW-1:0]   tmr, tmr_n;
    logic [AW-1:0]    acnt, acnt_n;
    logic             alarm_n, cooler_n, heater_n, raise, hot;
    logic             fault_n;
    logic [RPS_W-1:0] rps_n;
    logic signed [XW-1:0] tx, up_thr, dn_thr;

    function automatic logic [RPS_W-1:0] rps_of(input logic [LW-1:0] l);
        int v;
        if (l == '0) return '0;
        v = RPS_BASE + (int'(l) - 1) * RPS_STEP;
        if (v > (1 << RPS_W) - 1) v = (1 << RPS_W) - 1;
        return RPS_W'(v);
    endfunction

    // Fan thresholds are evaluated wide so large FAN_T0/level products cannot wrap.
    assign tx      = XW'($signed(t));
    assign up_thr  = XW'(FAN_T0 + int'(lvl) * FAN_STEP);
    assign dn_thr  = XW'(FAN_T0 + (int'(lvl) - 1) * FAN_STEP - FAN_HYS);
    assign hot     = $signed(t) > $signed(thr_alarm);
    assign mode_dbg = mode;

`ifdef INCUBATOR_SENSOR_WDT_EN
    localparam int WW = cw(WDT_CYC + 1);
    localparam logic [WW-1:0] W_MAX = WW'(WDT_CYC);
    logic [WW-1:0] wcnt, wcnt_n;
`else
    assign fault_n = 1'b0;
    assign fault   = 1'b0;
`endif

    always_comb begin
        mode_n  = mode;
        lvl_n   = lvl;
        tmr_n   = (tmr != '0) ? tmr - TMW'(1) : '0;
        acnt_n  = acnt;
        alarm_n = alarm;
        raise   = 1'b0;
`ifdef INCUBATOR_SENSOR_WDT_EN
        wcnt_n  = wcnt;
        fault_n = 1'b0;
`endif
        if (t_valid) begin
            acnt_n = !hot ? '0 : ((acnt == A_MAX) ? acnt : acnt + AW'(1));
            raise  = hot && (acnt_n == A_MAX);
            unique case (mode)
                IDLE: begin
                    if ($signed(t) > $signed(thr_hi)) begin
                        mode_n = COOL;
                        tmr_n  = T_LOAD;
                    end else if ($signed(t) < $signed(thr_lo)) begin
                        mode_n = HEAT;
                        tmr_n  = T_LOAD;
                    end
                end
                COOL: if ($signed(t) < $signed(thr_hi_clr) && tmr == '0) mode_n = IDLE;
                HEAT: if ($signed(t) > $signed(thr_lo_clr) && tmr == '0) mode_n = IDLE;
                default: mode_n = IDLE;
            endcase
            if (int'(lvl) < FAN_LVLS - 1 && tx > up_thr) lvl_n = lvl + LW'(1);
            else if (lvl != '0 && tx < dn_thr)            lvl_n = lvl - LW'(1);
        end
        // Clear returns the zone to a freshly started COOL; a same-edge raise still wins.
        if (alarm_clr && alarm) begin
            alarm_n = 1'b0;
            mode_n  = COOL;
            tmr_n   = T_LOAD;
        end
        if (raise) alarm_n = 1'b1;
        if (alarm_n) begin
            mode_n = COOL;
            lvl_n  = LVL_MAX;
            tmr_n  = T_LOAD;
        end
`ifdef INCUBATOR_SENSOR_WDT_EN
        wcnt_n  = t_valid ? '0 : ((wcnt == W_MAX) ? wcnt : wcnt + WW'(1));
        fault_n = !t_valid && (fault || wcnt_n == W_MAX);
        if (fault_n) begin
            lvl_n  = LVL_MAX;
            mode_n = alarm_n ? COOL : IDLE;
        end
`endif
        cooler_n = (mode_n == COOL) && !fault_n;
        heater_n = (mode_n == HEAT) && !fault_n;
        rps_n    = rps_of(lvl_n);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode   <= IDLE;
            lvl    <= '0;
            tmr    <= '0;
            acnt   <= '0;
            alarm  <= 1'b0;
            cooler <= 1'b0;
            heater <= 1'b0;
            rps    <= '0;
        end else begin
            mode   <= mode_n;
            lvl    <= lvl_n;
            tmr    <= tmr_n;
            acnt   <= acnt_n;
            alarm  <= alarm_n;
            cooler <= cooler_n;
            heater <= heater_n;
            rps    <= rps_n;
        end
    end

`ifdef INCUBATOR_SENSOR_WDT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt  <= '0;
            fault <= 1'b0;
        end else begin
            wcnt  <= wcnt_n;
            fault <= fault_n;
        end
    end
`endif

endmodule

// File: rtl/incubator_mc.sv
// Multi-zone incubator controller: NCH independent zones sharing thresholds.
// Define INCUBATOR_SENSOR_WDT_EN to build the per-zone sensor watchdog.
module incubator_mc
    import incubator_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int TW        = 8,
    parameter int FAN_LVLS  = 4,
    parameter int FAN_T0    = 35,
    parameter int FAN_STEP  = 5,
    parameter int FAN_HYS   = 5,
    parameter int RPS_W     = 4,
    parameter int RPS_BASE  = 4,
    parameter int RPS_STEP  = 2,
    parameter int MIN_ON    = 16,
    parameter int ALARM_CNT = 4
`ifdef INCUBATOR_SENSOR_WDT_EN
    ,
    parameter int WDT_CYC   = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       t_valid,
    input  logic [NCH*TW-1:0]    t,
    input  logic [TW-1:0]        thr_hi,
    input  logic [TW-1:0]        thr_hi_clr,
    input  logic [TW-1:0]        thr_lo,
    input  logic [TW-1:0]        thr_lo_clr,
    input  logic [TW-1:0]        thr_alarm,
    input  logic                 alarm_clr,
    output logic [NCH-1:0]       cooler,
    output logic [NCH-1:0]       heater,
    output logic [NCH*RPS_W-1:0] rps,
    output logic [NCH-1:0]       alarm,
    output logic [NCH-1:0]       fault,
    output logic [2*NCH-1:0]     mode_dbg
);

    for (genvar i = 0; i < NCH; i++) begin : g_zone
        incubator_zone #(
            .TW(TW), .FAN_LVLS(FAN_LVLS), .FAN_T0(FAN_T0), .FAN_STEP(FAN_STEP),
            .FAN_HYS(FAN_HYS), .RPS_W(RPS_W), .RPS_BASE(RPS_BASE),
            .RPS_STEP(RPS_STEP), .MIN_ON(MIN_ON), .ALARM_CNT(ALARM_CNT)
`ifdef INCUBATOR_SENSOR_WDT_EN
            , .WDT_CYC(WDT_CYC)
`endif
        ) u_zone (
            .clk        (clk),
            .rst        (rst),
            .t_valid    (t_valid[i]),
            .t          (t[i*TW +: TW]),
            .thr_hi     (thr_hi),
            .thr_hi_clr (thr_hi_clr),
            .thr_lo     (thr_lo),
            .thr_lo_clr (thr_lo_clr),
            .thr_alarm  (thr_alarm),
            .alarm_clr  (alarm_clr),
            .cooler     (cooler[i]),
            .heater     (heater[i]),
            .rps        (rps[i*RPS_W +: RPS_W]),
            .alarm      (alarm[i]),
            .fault      (fault[i]),
            .mode_dbg   (mode_dbg[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_incubator_mc.sv
// Self-checking bench for incubator_mc against a cycle-level behavioural model.
module tb_incubator_mc;
    import incubator_pkg::*;

    localparam int NCH = 2, TW = 8, RPS_W = 4, FAN_LVLS = 4, FAN_T0 = 35;
    localparam int FAN_STEP = 5, FAN_HYS = 5, RPS_BASE = 4, RPS_STEP = 2;
    localparam int MIN_ON = 16, ALARM_CNT = 4;
`ifdef INCUBATOR_SENSOR_WDT_EN
    localparam bit WDT_ON = 1'b1;
    localparam int WDT = 64;
`else
    localparam bit WDT_ON = 1'b0;
    localparam int WDT = 1024;
`endif

    logic                 clk, rst, alarm_clr;
    logic [NCH-1:0]       t_valid, cooler, heater, alarm, fault;
    logic [NCH*TW-1:0]    t;
    logic [TW-1:0]        thr_hi, thr_hi_clr, thr_lo, thr_lo_clr, thr_alarm;
    logic [NCH*RPS_W-1:0] rps;
    logic [2*NCH-1:0]     mode_dbg;

    incubator_mc #(
        .NCH(NCH), .TW(TW), .FAN_LVLS(FAN_LVLS), .FAN_T0(FAN_T0), .FAN_STEP(FAN_STEP),
        .FAN_HYS(FAN_HYS), .RPS_W(RPS_W), .RPS_BASE(RPS_BASE), .RPS_STEP(RPS_STEP),
        .MIN_ON(MIN_ON), .ALARM_CNT(ALARM_CNT)
`ifdef INCUBATOR_SENSOR_WDT_EN
        , .WDT_CYC(WDT)
`endif
    ) dut (
        .clk(clk), .rst(rst), .t_valid(t_valid), .t(t),
        .thr_hi(thr_hi), .thr_hi_clr(thr_hi_clr), .thr_lo(thr_lo),
        .thr_lo_clr(thr_lo_clr), .thr_alarm(thr_alarm), .alarm_clr(alarm_clr),
        .cooler(cooler), .heater(heater), .rps(rps), .alarm(alarm),
        .fault(fault), .mode_dbg(mode_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 0 = idle, 1 = cooling, 2 = heating.
    int m_mode[NCH], m_lvl[NCH], m_entry[NCH], m_hot[NCH], m_nv[NCH];
    bit m_alarm[NCH], m_fault[NCH];
    int cyc, errors, checks;

    task automatic model_reset();
        for (int z = 0; z < NCH; z++) begin
            m_mode[z] = 0; m_lvl[z] = 0; m_entry[z] = -1000; m_hot[z] = 0;
            m_nv[z] = 0; m_alarm[z] = 1'b0; m_fault[z] = 1'b0;
        end
    endtask

    function automatic int sval(input logic [TW-1:0] v);
        logic signed [TW-1:0] s;
        s = v;
        return int'(s);
    endfunction

    function automatic int m_rps(input int l);
        int v;
        if (l == 0) return 0;
        v = RPS_BASE + (l - 1) * RPS_STEP;
        return (v > (1 << RPS_W) - 1) ? (1 << RPS_W) - 1 : v;
    endfunction

    task automatic model_edge();
        int tv, hi, hic, lo, loc, al;
        bit v;
        cyc++;
        hi = sval(thr_hi); hic = sval(thr_hi_clr); lo = sval(thr_lo);
        loc = sval(thr_lo_clr); al = sval(thr_alarm);
        for (int z = 0; z < NCH; z++) begin
            v  = t_valid[z];
            tv = sval(t[z*TW +: TW]);
            if (v) begin
                m_hot[z] = (tv > al) ? m_hot[z] + 1 : 0;
                if (!m_alarm[z]) begin
                    if (m_mode[z] == 0) begin
                        if (tv > hi)      begin m_mode[z] = 1; m_entry[z] = cyc; end
                        else if (tv < lo) begin m_mode[z] = 2; m_entry[z] = cyc; end
                    end else if (m_mode[z] == 1) begin
                        if (tv < hic && cyc - m_entry[z] >= MIN_ON) m_mode[z] = 0;
                    end else begin
                        if (tv > loc && cyc - m_entry[z] >= MIN_ON) m_mode[z] = 0;
                    end
                end
                if (m_lvl[z] < FAN_LVLS - 1 && tv > FAN_T0 + m_lvl[z] * FAN_STEP)
                    m_lvl[z]++;
                else if (m_lvl[z] > 0 && tv < FAN_T0 + (m_lvl[z] - 1) * FAN_STEP - FAN_HYS)
                    m_lvl[z]--;
            end
            if (alarm_clr && m_alarm[z]) begin
                m_alarm[z] = 1'b0; m_mode[z] = 1; m_entry[z] = cyc;
            end
            if (v && m_hot[z] >= ALARM_CNT) m_alarm[z] = 1'b1;
            if (m_alarm[z]) begin m_mode[z] = 1; m_lvl[z] = FAN_LVLS - 1; end
            if (WDT_ON) begin
                if (v) begin
                    m_nv[z] = 0; m_fault[z] = 1'b0;
                end else begin
                    if (m_nv[z] < WDT) m_nv[z]++;
                    if (m_nv[z] == WDT) m_fault[z] = 1'b1;
                end
                if (m_fault[z]) begin
                    m_lvl[z] = FAN_LVLS - 1; m_mode[z] = m_alarm[z] ? 1 : 0;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_vec(input int z);
        return {m_mode[z] == 1 && !m_fault[z], m_mode[z] == 2 && !m_fault[z],
                RPS_W'(m_rps(m_lvl[z])), m_alarm[z], m_fault[z]};
    endfunction

    function automatic logic [7:0] dut_vec(input int z);
        return {cooler[z], heater[z], rps[z*RPS_W +: RPS_W], alarm[z], fault[z]};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic drive(input bit v0, input int t0, input bit v1, input int t1);
        t_valid = {v1, v0};
        t = {TW'(t1), TW'(t0)};
    endtask

    task automatic set_thr(input int hi, input int hic, input int lo, input int loc, input int al);
        thr_hi = TW'(hi); thr_hi_clr = TW'(hic); thr_lo = TW'(lo);
        thr_lo_clr = TW'(loc); thr_alarm = TW'(al);
    endtask

    task automatic test_reset();
        rst = 1'b0; alarm_clr = 1'b0; drive(0, 0, 0, 0);
        set_thr(DEF_THR_HI, DEF_THR_HI_CLR, DEF_THR_LO, DEF_THR_LO_CLR, DEF_THR_ALARM);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int z = 0; z < NCH; z++) begin
            checks++;
            if (dut_vec(z) !== 8'h00) begin
                errors++; $display("FAIL reset_outputs z%0d: got %h want 00", z, dut_vec(z));
            end
            checks++;
            if (mode_dbg[2*z +: 2] !== IDLE) begin
                errors++; $display("FAIL reset_mode z%0d: got %0d want %0d", z, mode_dbg[2*z +: 2], IDLE);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_cool_entry();
        drive(1, 36, 0, 0);
        tick();
        checks++;
        if (dut_vec(0) !== exp_vec(0)) begin
            errors++; $display("FAIL cool_entry z0: got %h want %h", dut_vec(0), exp_vec(0));
        end
        checks++;
        if (cooler[0] !== 1'b1 || rps[3:0] !== 4'd4) begin
            errors++; $display("FAIL cool_entry_abs z0: got cooler=%b rps=%0d want cooler=1 rps=4", cooler[0], rps[3:0]);
        end
        checks++;
        if (dut_vec(1) !== 8'h00) begin
            errors++; $display("FAIL zone_isolation z1: got %h want 00", dut_vec(1));
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_min_on();
        // Entry edge was the previous tick; exits are legal from MIN_ON edges later.
        tick(); tick();
        drive(1, 20, 0, 0); tick(); drive(0, 0, 0, 0);
        checks++;
        if (cooler[0] !== 1'b1 || dut_vec(0) !== exp_vec(0)) begin
            errors++; $display("FAIL min_on_hold_early z0: got %h want %h", dut_vec(0), exp_vec(0));
        end
        repeat (11) tick();
        drive(1, 20, 0, 0); tick();
        checks++;
        if (cooler[0] !== 1'b1 || dut_vec(0) !== exp_vec(0)) begin
            errors++; $display("FAIL min_on_hold_last z0: got %h want %h", dut_vec(0), exp_vec(0));
        end
        tick(); drive(0, 0, 0, 0);
        checks++;
        if (cooler[0] !== 1'b0 || dut_vec(0) !== exp_vec(0)) begin
            errors++; $display("FAIL min_on_release z0: got %h want %h", dut_vec(0), exp_vec(0));
        end
    endtask

    task automatic test_fan();
        int temps[7] = '{36, 41, 46, 46, 39, 34, 29};
        int want[7]  = '{4, 6, 8, 8, 6, 4, 0};
        for (int i = 0; i < 7; i++) begin
            drive(1, temps[i], 0, 0);
            tick();
            checks++;
            if (rps[3:0] !== 4'(want[i]) || dut_vec(0) !== exp_vec(0)) begin
                errors++; $display("FAIL fan_step%0d z0: got rps=%0d vec=%h want rps=%0d vec=%h",
                                   i, rps[3:0], dut_vec(0), want[i], exp_vec(0));
            end
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_alarm();
        for (int i = 0; i < 4; i++) begin
            drive(1, 51, 0, 0); tick();
            checks++;
            if (dut_vec(0) !== exp_vec(0) || alarm[0] !== (i == 3)) begin
                errors++; $display("FAIL alarm_count%0d z0: got %h want %h", i, dut_vec(0), exp_vec(0));
            end
        end
        checks++;
        if (heater[0] !== 1'b0 || cooler[0] !== 1'b1 || rps[3:0] !== 4'd8) begin
            errors++; $display("FAIL alarm_force z0: got c=%b h=%b rps=%0d want c=1 h=0 rps=8", cooler[0], heater[0], rps[3:0]);
        end
        drive(1, 10, 0, 0); tick();
        checks++;
        if (alarm[0] !== 1'b1 || dut_vec(0) !== exp_vec(0)) begin
            errors++; $display("FAIL alarm_sticky z0: got %h want %h", dut_vec(0), exp_vec(0));
        end
        drive(0, 0, 0, 0); alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
        checks++;
        if (alarm[0] !== 1'b0 || cooler[0] !== 1'b1 || dut_vec(0) !== exp_vec(0)) begin
            errors++; $display("FAIL alarm_clear z0: got %h want %h", dut_vec(0), exp_vec(0));
        end
        drive(1, 10, 0, 0); tick(); drive(0, 0, 0, 0);
        checks++;
        if (dut_vec(0) !== exp_vec(0)) begin
            errors++; $display("FAIL alarm_reload z0: got %h want %h", dut_vec(0), exp_vec(0));
        end
        // Zone 1: the fourth hot sample coincides with a clear pulse.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 60); alarm_clr = (i == 3); tick();
        end
        alarm_clr = 1'b0; drive(0, 0, 0, 0);
        checks++;
        if (alarm[1] !== 1'b1 || dut_vec(1) !== exp_vec(1)) begin
            errors++; $display("FAIL raise_beats_clear z1: got %h want %h", dut_vec(1), exp_vec(1));
        end
        alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
        checks++;
        if (alarm[1] !== 1'b0 || dut_vec(1) !== exp_vec(1)) begin
            errors++; $display("FAIL clear_after_raise z1: got %h want %h", dut_vec(1), exp_vec(1));
        end
    endtask

    task automatic test_boundary();
        int temps[4] = '{35, 15, 14, 30};
        logic [7:0] want[4] = '{8'h00, 8'h00, 8'h40, 8'h40};
        rst = 1'b0; #2; model_reset(); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                drive(0, 0, 0, 0);
                repeat (15) tick();
            end
            drive(1, temps[i], 0, 0); tick();
            checks++;
            if (dut_vec(0) !== want[i] || dut_vec(0) !== exp_vec(0)) begin
                errors++; $display("FAIL boundary_t%0d z0: got %h want %h", temps[i], dut_vec(0), want[i]);
            end
        end
        drive(1, 31, 0, 0); tick();
        checks++;
        if (heater[0] !== 1'b0 || dut_vec(0) !== exp_vec(0)) begin
            errors++; $display("FAIL heat_release z0: got %h want %h", dut_vec(0), exp_vec(0));
        end
        drive(1, 14, 0, 0); tick(); drive(0, 0, 0, 0);
        rst = 1'b0; #2;
        checks++;
        if (heater !== '0 || cooler !== '0 || rps !== '0 || alarm !== '0) begin
            errors++; $display("FAIL async_reset: got h=%b c=%b rps=%h a=%b want all 0", heater, cooler, rps, alarm);
        end
        model_reset();
        tick(); rst = 1'b1;
    endtask

    task automatic test_random();
        int t0, t1, hi, lo;
        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 0) begin
                hi = int'($urandom_range(20, 60)); lo = int'($urandom_range(0, 35)) - 10;
                set_thr(hi, hi - int'($urandom_range(0, 15)), lo,
                        lo + int'($urandom_range(0, 15)), int'($urandom_range(30, 80)));
            end
            t0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 110)) - 20;
            t1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 110)) - 20;
            drive($urandom_range(0, 3) != 0, t0, $urandom_range(0, 3) != 0, t1);
            alarm_clr = ($urandom_range(0, 29) == 0);
            tick();
            for (int z = 0; z < NCH; z++) begin
                checks++;
                if (dut_vec(z) !== exp_vec(z)) begin
                    errors++; $display("FAIL random n%0d z%0d: got %h want %h", n, z, dut_vec(z), exp_vec(z));
                end
            end
        end
        alarm_clr = 1'b0; drive(0, 0, 0, 0);
    endtask

`ifdef INCUBATOR_SENSOR_WDT_EN
    task automatic test_wdt();
        drive(1, 20, 1, 20); tick(); drive(0, 0, 0, 0);
        repeat (WDT - 1) tick();
        checks++;
        if (fault[0] !== 1'b0 || dut_vec(0) !== exp_vec(0)) begin
            errors++; $display("FAIL wdt_early z0: got %h want %h", dut_vec(0), exp_vec(0));
        end
        tick();
        checks++;
        if (fault[0] !== 1'b1 || cooler[0] !== 1'b0 || heater[0] !== 1'b0 || rps[3:0] !== 4'd8) begin
            errors++; $display("FAIL wdt_timeout z0: got %h want fault=1 relays=0 rps=8", dut_vec(0));
        end
        drive(1, 20, 1, 20); tick(); drive(0, 0, 0, 0);
        checks++;
        if (fault[0] !== 1'b0 || dut_vec(0) !== exp_vec(0)) begin
            errors++; $display("FAIL wdt_recover z0: got %h want %h", dut_vec(0), exp_vec(0));
        end
    endtask
`endif

    initial begin
        errors = 0; checks = 0; cyc = 0;
        test_reset();
        test_cool_entry();
        test_min_on();
        test_fan();
        test_alarm();
        test_boundary();
        set_thr(DEF_THR_HI, DEF_THR_HI_CLR, DEF_THR_LO, DEF_THR_LO_CLR, DEF_THR_ALARM);
        test_random();
`ifdef INCUBATOR_SENSOR_WDT_EN
        test_wdt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
